// File: rtl/hdc_pkg.sv
// Shared constants and types for the HDC classifier front end.
package hdc_pkg;

  // Frame geometry; 2**LEN_WIDTH must exceed MESSAGE_LENGTH so the
  // saturated count still fits in length_out.
  localparam int MESSAGE_LENGTH = 200;
  localparam int CHAR_LENGTH    = 8;
  localparam int LEN_WIDTH      = 8;

  // Label encoding understood by the classifier (2'b10 is unused).
  typedef enum logic [1:0] {
    LABEL_HAM          = 2'b00,
    LABEL_SPAM         = 2'b01,
    LABEL_INCONCLUSIVE = 2'b11
  } label_e;

  // Loader frame state.
  typedef enum logic [1:0] {
    FILL  = 2'b00,
    DRAIN = 2'b01,
    HOLD  = 2'b10
  } loader_state_e;

endpackage : hdc_pkg

// File: rtl/char_packer.sv
// Message buffer for the stream loader: writes one character into its
// MSB-first byte lane per accepted beat, or clears the whole frame.
module char_packer #(
  parameter int MESSAGE_LENGTH = hdc_pkg::MESSAGE_LENGTH,
  parameter int CHAR_LENGTH    = hdc_pkg::CHAR_LENGTH,
  parameter int LEN_WIDTH      = hdc_pkg::LEN_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  wr_en,
  input  logic [LEN_WIDTH-1:0]                  wr_idx,
  input  logic [CHAR_LENGTH-1:0]                wr_data,
  output logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg
);

  import hdc_pkg::*;

  localparam int MSG_W = CHAR_LENGTH * MESSAGE_LENGTH;

  logic [MSG_W-1:0] msg_q;
  logic [MSG_W-1:0] msg_d;

  // Lane decode: index 0 lands in the top byte, later characters move down.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise paths
    // that do not assign it would infer a latch.
    msg_d = msg_q;
    if (clear) begin
      msg_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < MESSAGE_LENGTH; i++) begin
        if (wr_idx == LEN_WIDTH'(i)) begin
          msg_d[CHAR_LENGTH*(MESSAGE_LENGTH-1-i) +: CHAR_LENGTH] = wr_data;
        end
      end
    end
  end

  // Frame storage register.
  always_ff @(posedge clk) begin
    // NOTE: this wide buffer is reset on purpose: unwritten lanes must read
    // as zero, so it cannot be treated as a don't-care memory.
    if (reset) begin
      msg_q <= '0;
    end else begin
      msg_q <= msg_d;
    end
  end

  assign msg = msg_q;

endmodule : char_packer

// File: rtl/msg_stream_loader.sv
// Streaming character loader for the HDC classifier: accepts bytes over a
// valid/ready handshake, packs them MSB-first into one frame word, counts
// them, captures the expected tag and presents the finished frame.
module msg_stream_loader #(
  parameter int MESSAGE_LENGTH = hdc_pkg::MESSAGE_LENGTH,
  parameter int CHAR_LENGTH    = hdc_pkg::CHAR_LENGTH,
  parameter int LEN_WIDTH      = hdc_pkg::LEN_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  // character stream in
  input  logic                                  char_valid,
  input  logic [CHAR_LENGTH-1:0]                char_data,
  input  logic                                  char_last,
  input  logic [1:0]                            char_tag,
  output logic                                  char_ready,
  // frame out
  output logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg_out,
  output logic [LEN_WIDTH-1:0]                  length_out,
  output logic [1:0]                            tag_out,
  output logic                                  overflow,
  output logic                                  msg_valid,
  input  logic                                  msg_ready
);

  import hdc_pkg::*;

  localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(MESSAGE_LENGTH - 1);

  loader_state_e        state_q, state_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [1:0]           tag_q, tag_d;
  logic                 overflow_q, overflow_d;
  logic                 char_ready_q, char_ready_d;
  logic                 msg_valid_q, msg_valid_d;

  logic beat_xfer;
  logic frame_xfer;
  logic pack_wr;
  logic pack_clear;

  assign beat_xfer  = char_valid && char_ready_q;
  assign frame_xfer = msg_valid_q && msg_ready;

  // Next-state and next-output logic of the frame FSM.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tag_d      = tag_q;
    overflow_d = overflow_q;
    pack_wr    = 1'b0;
    pack_clear = 1'b0;

    unique case (state_q)
      FILL: begin
        if (beat_xfer) begin
          pack_wr = 1'b1;
          count_d = count_q + LEN_WIDTH'(1);
          if (char_last) begin
            // A last beat that also fills the buffer is not an overflow.
            tag_d   = char_tag;
            state_d = HOLD;
          end else if (count_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Buffer is full: keep accepting so the source can finish the frame,
        // but drop the bytes and flag the truncation.
        if (beat_xfer) begin
          overflow_d = 1'b1;
          if (char_last) begin
            tag_d   = char_tag;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // Outputs frozen until the consumer takes the frame; the next
        // frame starts from an empty buffer one cycle later.
        if (frame_xfer) begin
          pack_clear = 1'b1;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // Handshake outputs are registered and follow the next state.
    char_ready_d = (state_d != HOLD);
    msg_valid_d  = (state_d == HOLD);
  end

  // Frame FSM state and registered outputs; reset wins over both handshakes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of evaluation order.
    if (reset) begin
      state_q      <= FILL;
      count_q      <= '0;
      tag_q        <= '0;
      overflow_q   <= 1'b0;
      char_ready_q <= 1'b1;
      msg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
      overflow_q   <= overflow_d;
      char_ready_q <= char_ready_d;
      msg_valid_q  <= msg_valid_d;
    end
  end

  char_packer #(
    .MESSAGE_LENGTH (MESSAGE_LENGTH),
    .CHAR_LENGTH    (CHAR_LENGTH),
    .LEN_WIDTH      (LEN_WIDTH)
  ) u_char_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (pack_clear),
    .wr_en   (pack_wr),
    .wr_idx  (count_q),
    .wr_data (char_data),
    .msg     (msg_out)
  );

  assign char_ready = char_ready_q;
  assign length_out = count_q;
  assign tag_out    = tag_q;
  assign overflow   = overflow_q;
  assign msg_valid  = msg_valid_q;

endmodule : msg_stream_loader

// File: tb/tb_msg_stream_loader.sv
// Self-checking bench for msg_stream_loader: a scoreboard of expected frames
// is filled as characters are driven and drained when a frame is presented.
module tb_msg_stream_loader;

  import hdc_pkg::*;

  localparam int ML     = MESSAGE_LENGTH;
  localparam int CL     = CHAR_LENGTH;
  localparam int LW     = LEN_WIDTH;
  localparam int MSG_W  = CL * ML;
  localparam int NCHUNK = MSG_W / 64;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [MSG_W-1:0] msg;
    logic [LW-1:0]    len;
    logic [1:0]       tag;
    logic             ovf;
  } frame_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             char_valid;
  logic [CL-1:0]    char_data;
  logic             char_last;
  logic [1:0]       char_tag;
  logic             char_ready;
  logic [MSG_W-1:0] msg_out;
  logic [LW-1:0]    length_out;
  logic [1:0]       tag_out;
  logic             overflow;
  logic             msg_valid;
  logic             msg_ready;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     hs_cyc   = 0;
  frame_t sb[$];
  logic   seen     = 1'b0;

  msg_stream_loader dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_last  (char_last),
    .char_tag   (char_tag),
    .char_ready (char_ready),
    .msg_out    (msg_out),
    .length_out (length_out),
    .tag_out    (tag_out),
    .overflow   (overflow),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop the oldest expected frame and compare every field of the DUT frame.
  task automatic compare_frame();
    frame_t e;
    if (sb.size() == 0) begin
      check("sb_pop_empty", 64'(1), 64'(0));
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < NCHUNK; k++) begin
      check($sformatf("msg_chunk%0d", k), msg_out[64*k +: 64], e.msg[64*k +: 64]);
    end
    check("frame_len", 64'(length_out), 64'(e.len));
    check("frame_tag", 64'(tag_out), 64'(e.tag));
    check("frame_ovf", 64'(overflow), 64'(e.ovf));
  endtask

  // Frame monitor: compare once on each rising msg_valid.
  always @(negedge clk) begin
    if (msg_valid && !seen) begin
      seen = 1'b1;
      compare_frame();
    end else if (!msg_valid) begin
      seen = 1'b0;
    end
  end

  // Drive one beat and wait (bounded) until it is accepted.
  task automatic drive_beat(input logic [7:0] d, input logic last, input logic [1:0] tag,
                            output int acc_cyc, output int waited);
    int n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = d;
    char_last  = last;
    char_tag   = tag;
    while (!char_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) check("beat_wait_timeout", 64'(char_ready), 64'(1));
    acc_cyc = cyc;
    waited  = n;
    @(posedge clk);
  endtask

  // Push the expected frame, stream its bytes, then check valid latency.
  task automatic send_frame(input byte_q_t b, input logic [1:0] tag, input int gap,
                            output int first_cyc);
    frame_t e;
    int     acc;
    int     w;
    int     n = b.size();
    e.msg = '0;
    for (int i = 0; i < n && i < ML; i++) e.msg[MSG_W-1-CL*i -: CL] = b[i];
    e.len = LW'((n > ML) ? ML : n);
    e.tag = tag;
    e.ovf = (n > ML);
    sb.push_back(e);
    first_cyc = 0;
    for (int i = 0; i < n; i++) begin
      drive_beat(b[i], (i == n - 1), tag, acc, w);
      if (i == 0) first_cyc = acc;
      if (i >= ML) check("drain_ready", 64'(w), 64'(0));
      if (gap > 0 && i < n - 1) begin
        @(negedge clk);
        char_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    char_valid = 1'b0;
    char_last  = 1'b0;
    check("valid_latency", 64'(msg_valid), 64'(1));
    check("hold_not_ready", 64'(char_ready), 64'(0));
  endtask

  // Wait for a frame, hold it for `delay` cycles, then take it.
  task automatic consume(input int delay);
    int            n = 0;
    logic [LW-1:0] len0;
    @(negedge clk);
    while (!msg_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!msg_valid) begin
      check("consume_timeout", 64'(msg_valid), 64'(1));
      return;
    end
    len0 = length_out;
    repeat (delay) begin
      @(negedge clk);
      check("hold_ready", 64'(char_ready), 64'(0));
      check("hold_len", 64'(length_out), 64'(len0));
    end
    msg_ready = 1'b1;
    hs_cyc    = cyc;
    @(negedge clk);
    msg_ready = 1'b0;
    check("rel_valid", 64'(msg_valid), 64'(0));
    check("rel_len", 64'(length_out), 64'(0));
    check("rel_msg_zero", 64'(|msg_out), 64'(0));
    check("rel_ovf", 64'(overflow), 64'(0));
    check("rel_ready", 64'(char_ready), 64'(1));
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(1, 255)));
    return q;
  endfunction

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_msg"}, 64'(|msg_out), 64'(0));
    check({pfx, "_len"}, 64'(length_out), 64'(0));
    check({pfx, "_tag"}, 64'(tag_out), 64'(0));
    check({pfx, "_ovf"}, 64'(overflow), 64'(0));
    check({pfx, "_valid"}, 64'(msg_valid), 64'(0));
    check({pfx, "_ready"}, 64'(char_ready), 64'(1));
  endtask

  initial begin
    byte_q_t b;
    byte_q_t b2;
    int      fc;
    int      acc;
    int      w;

    reset      = 1'b1;
    char_valid = 1'b0;
    char_data  = '0;
    char_last  = 1'b0;
    char_tag   = '0;
    msg_ready  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    // "HI" with spam tag, held for a few cycles before release.
    b = '{8'h48, 8'h49};
    send_frame(b, LABEL_SPAM, 0, fc);
    check("hi_top16", 64'(msg_out[MSG_W-1 -: 16]), 64'(16'h4849));
    consume(3);

    // Exactly full frame: last beat fills the buffer, no overflow.
    b = rand_bytes(ML);
    send_frame(b, LABEL_HAM, 0, fc);
    check("full_last_byte", 64'(msg_out[7:0]), 64'(b[ML-1]));
    check("full_ovf", 64'(overflow), 64'(0));
    consume(1);

    // Truncated frame: three extra beats are accepted and discarded.
    b = rand_bytes(ML + 3);
    send_frame(b, LABEL_INCONCLUSIVE, 0, fc);
    consume(0);

    // Back-to-back: an overflowed frame, then a short one queued behind it.
    b  = rand_bytes(ML + 1);
    b2 = rand_bytes(2);
    send_frame(b, LABEL_SPAM, 0, fc);
    fork
      consume(3);
      send_frame(b2, LABEL_HAM, 0, fc);
    join
    check("b2b_after_hs", 64'(fc > hs_cyc), 64'(1));
    consume(2);

    // Gapped source: valid toggles every other cycle.
    b = rand_bytes(7);
    send_frame(b, LABEL_INCONCLUSIVE, 1, fc);
    consume(0);

    // Reset in the middle of a frame discards it.
    b = rand_bytes(5);
    for (int i = 0; i < 5; i++) drive_beat(b[i], 1'b0, LABEL_SPAM, acc, w);
    @(negedge clk);
    char_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check_idle_zero("midrst");
    reset = 1'b0;
    b = '{8'h41};
    send_frame(b, LABEL_SPAM, 0, fc);
    check("one_len", 64'(length_out), 64'(1));
    check("one_top", 64'(msg_out[MSG_W-1 -: 8]), 64'(8'h41));
    consume(0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures = failures + 1;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_msg_stream_loader
